// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the fetch and load/store
// ports with round-robin grant, one outstanding access and fixed MEM_LATENCY.
// Ports:
//   clk, reset                 clock, async active-high reset
//   i_req_*/i_flush/i_resp_*   fetch request, flush, response pulse
//   d_req_*/d_resp_*           load/store request, response pulse
//   mem_*                      memory issue strobe, payload and read data
module mem_arbiter #(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req_valid,
  input  logic [31:0] i_req_addr,
  output logic        i_req_ready,
  input  logic        i_flush,
  output logic        i_resp_valid,
  output logic [31:0] i_resp_data,
  output logic        i_resp_err,
  input  logic        d_req_valid,
  input  logic [31:0] d_req_addr,
  input  logic        d_req_we,
  input  logic [2:0]  d_req_width,
  input  logic [31:0] d_req_wdata,
  output logic        d_req_ready,
  output logic        d_resp_valid,
  output logic [31:0] d_resp_data,
  output logic        d_resp_err,
  output logic        mem_en,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [2:0]  mem_width,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ERR
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  // last_d = 1 means data won the last grant
  logic       last_d, last_d_nx;
  logic       owner_d, owner_d_nx;
  logic       owner_we, owner_we_nx;
  logic       flushed, flushed_nx;

  logic idle;
  logic grant_i;
  logic grant_d;
  logic i_mis;
  logic d_mis;
  logic mis;
  logic fin;
  logic err_now;
  logic i_show;
  logic d_show;

  assign idle    = (state == IDLE) && !reset;
  assign grant_i = idle && i_req_valid
                   && (!d_req_valid || last_d);
  assign grant_d = idle && d_req_valid && !grant_i;

  assign i_mis = (i_req_addr[1:0] != 2'b00);

  always_comb begin
    d_mis = 1'b0;
    unique case (d_req_width)
      3'd1, 3'd5: d_mis = d_req_addr[0];
      3'd2:       d_mis = (d_req_addr[1:0] != 2'b00);
      default:    d_mis = 1'b0;
    endcase
  end

  assign mis = grant_i ? i_mis : d_mis;

  // final cycle of a transaction: WAIT at zero or the single ERR cycle
  assign fin = !reset
               && ((state == WAIT && cnt == 4'd0)
                   || state == ERR);
  assign err_now = (state == ERR);

  // a flush in the final cycle itself also suppresses the fetch pulse
  assign i_show = fin && !owner_d && !flushed && !i_flush;
  assign d_show = fin && owner_d;

  assign i_req_ready = grant_i;
  assign d_req_ready = grant_d;

  always_comb begin
    mem_en    = 1'b0;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_width = '0;
    mem_wdata = '0;
    if ((grant_i || grant_d) && !mis) begin
      mem_en = 1'b1;
      if (grant_i) begin
        mem_addr  = i_req_addr;
        mem_width = 3'd2;
      end else begin
        mem_addr  = d_req_addr;
        mem_we    = d_req_we;
        mem_width = d_req_width;
        mem_wdata = d_req_wdata;
      end
    end
  end

  assign i_resp_valid = i_show;
  assign i_resp_err   = i_show && err_now;
  assign i_resp_data  = (i_show && !err_now) ? mem_rdata : '0;

  assign d_resp_valid = d_show;
  assign d_resp_err   = d_show && err_now;
  assign d_resp_data  = (d_show && !err_now && !owner_we)
                        ? mem_rdata : '0;

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    last_d_nx   = last_d;
    owner_d_nx  = owner_d;
    owner_we_nx = owner_we;
    flushed_nx  = flushed;
    unique case (state)
      IDLE: begin
        if (grant_i || grant_d) begin
          owner_d_nx  = grant_d;
          owner_we_nx = grant_d && d_req_we;
          last_d_nx   = grant_d;
          flushed_nx  = 1'b0;
          if (mis) begin
            state_nx = ERR;
          end else begin
            state_nx = WAIT;
            cnt_nx   = LAT_M1;
          end
        end
      end
      WAIT: begin
        if (!owner_d && i_flush) flushed_nx = 1'b1;
        if (cnt == 4'd0) state_nx = IDLE;
        else cnt_nx = cnt - 4'd1;
      end
      ERR: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      last_d   <= 1'b1;
      owner_d  <= 1'b0;
      owner_we <= 1'b0;
      flushed  <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      last_d   <= last_d_nx;
      owner_d  <= owner_d_nx;
      owner_we <= owner_we_nx;
      flushed  <= flushed_nx;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a
// cycle-timestamp reference model and a small behavioural memory.
module tb_mem_arbiter;

  localparam int LAT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        i_v, i_rdy, i_fl, i_rv, i_re;
  logic [31:0] i_a, i_rd;
  logic        d_v, d_we, d_rdy, d_rv, d_re;
  logic [2:0]  d_w;
  logic [31:0] d_a, d_wd, d_rd;
  logic        m_en, m_we;
  logic [2:0]  m_w;
  logic [31:0] m_a, m_wd, m_rd;

  logic        i1_v, i1_rdy, i1_rv, i1_re;
  logic [31:0] i1_a, i1_rd;
  logic        d1_rdy, d1_rv, d1_re;
  logic [31:0] d1_rd;
  logic        m1_en, m1_we;
  logic [2:0]  m1_w;
  logic [31:0] m1_a, m1_wd, m1_rd;

  int errors = 0;
  int checks = 0;

  mem_arbiter #(.MEM_LATENCY(LAT)) u_dut (
    .clk(clk), .reset(reset),
    .i_req_valid(i_v), .i_req_addr(i_a),
    .i_req_ready(i_rdy), .i_flush(i_fl),
    .i_resp_valid(i_rv), .i_resp_data(i_rd),
    .i_resp_err(i_re),
    .d_req_valid(d_v), .d_req_addr(d_a),
    .d_req_we(d_we), .d_req_width(d_w),
    .d_req_wdata(d_wd), .d_req_ready(d_rdy),
    .d_resp_valid(d_rv), .d_resp_data(d_rd),
    .d_resp_err(d_re),
    .mem_en(m_en), .mem_addr(m_a), .mem_we(m_we),
    .mem_width(m_w), .mem_wdata(m_wd),
    .mem_rdata(m_rd)
  );

  mem_arbiter #(.MEM_LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .i_req_valid(i1_v), .i_req_addr(i1_a),
    .i_req_ready(i1_rdy), .i_flush(1'b0),
    .i_resp_valid(i1_rv), .i_resp_data(i1_rd),
    .i_resp_err(i1_re),
    .d_req_valid(1'b0), .d_req_addr(32'h0),
    .d_req_we(1'b0), .d_req_width(3'd2),
    .d_req_wdata(32'h0), .d_req_ready(d1_rdy),
    .d_resp_valid(d1_rv), .d_resp_data(d1_rd),
    .d_resp_err(d1_re),
    .mem_en(m1_en), .mem_addr(m1_a), .mem_we(m1_we),
    .mem_width(m1_w), .mem_wdata(m1_wd),
    .mem_rdata(m1_rd)
  );

  function automatic logic [31:0] init_word(int i);
    return 32'hA5000000 ^ (32'(i) * 32'h00010203);
  endfunction

  // behavioural memory for the latency-3 instance
  logic [31:0] phys [0:63];
  logic [31:0] rd_addr;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 64; k++) phys[k] <= init_word(k);
      rd_addr <= '0;
    end else if (m_en) begin
      if (m_we) phys[m_a[7:2]] <= m_wd;
      rd_addr <= m_a;
    end
  end
  assign m_rd = phys[rd_addr[7:2]];

  // latency-1 instance sees a single program word at 0x10
  logic [31:0] rd1_addr;
  always @(posedge clk or posedge reset) begin
    if (reset) rd1_addr <= '0;
    else if (m1_en) rd1_addr <= m1_a;
  end
  assign m1_rd = (rd1_addr == 32'h10) ? 32'h00500093 : 32'h0;

  function automatic bit misaligned(bit is_d, logic [2:0] w,
                                    logic [31:0] a);
    if (!is_d) return a[1:0] != 2'b00;
    if (w == 3'd1 || w == 3'd5) return a[0];
    if (w == 3'd2) return a[1:0] != 2'b00;
    return 1'b0;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'h100 + 32'(4 * $urandom_range(0, 15));
    if ($urandom_range(0, 5) == 0) a = a + 32'($urandom_range(1, 3));
    return a;
  endfunction

  function automatic logic [2:0] pick_width();
    case ($urandom_range(0, 4))
      0: return 3'd0;
      1: return 3'd1;
      2: return 3'd2;
      3: return 3'd4;
      default: return 3'd5;
    endcase
  endfunction

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    i_v = 0; i_a = 0; i_fl = 0;
    d_v = 0; d_a = 0; d_we = 0; d_w = 0; d_wd = 0;
    i1_v = 0; i1_a = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    i_v = 1; i_a = 32'h10; i_fl = 0;
    d_v = 1; d_a = 32'h20; d_we = 1; d_w = 2; d_wd = 32'h1234;
    i1_v = 1; i1_a = 32'h10;
    #2;
    checks++;
    if ({i_rdy, d_rdy, m_en, m_a, m_we, m_w, m_wd,
         i_rv, i_rd, i_re, d_rv, d_rd, d_re} !== '0)
      begin errors++; $display("FAIL reset_outs: got nonzero, expected 0"); end
    checks++;
    if ({i1_rdy, d1_rdy, m1_en, m1_a, i1_rv, i1_rd, d1_rv} !== '0)
      begin errors++; $display("FAIL reset_outs_l1: got nonzero, expected 0"); end
    @(posedge clk);
  endtask

  task automatic test_fetch_lat1;
    do_reset;
    i1_v = 1; i1_a = 32'h10;
    @(negedge clk);
    checks++;
    if ({i1_rdy, m1_en, m1_we, m1_w, m1_a} !==
        {1'b1, 1'b1, 1'b0, 3'd2, 32'h10})
      begin errors++; $display("FAIL l1_issue: got %b %b %b %0d %h", i1_rdy, m1_en, m1_we, m1_w, m1_a); end
    nxt;
    i1_a = 32'h14;
    @(negedge clk);
    checks++;
    if ({i1_rv, i1_re, i1_rd} !== {1'b1, 1'b0, 32'h00500093})
      begin errors++; $display("FAIL l1_resp: got %b %b %h expected 1 0 00500093", i1_rv, i1_re, i1_rd); end
    checks++;
    if (i1_rdy !== 1'b0)
      begin errors++; $display("FAIL l1_no_accept_c1: got %b expected 0", i1_rdy); end
    nxt;
    @(negedge clk);
    checks++;
    if ({i1_rdy, m1_en, m1_a} !== {1'b1, 1'b1, 32'h14})
      begin errors++; $display("FAIL l1_accept_c2: got %b %b %h", i1_rdy, m1_en, m1_a); end
    nxt;
    i1_v = 0;
    @(negedge clk);
    checks++;
    if ({i1_rv, i1_rd} !== {1'b1, 32'h0})
      begin errors++; $display("FAIL l1_resp2: got %b %h expected 1 0", i1_rv, i1_rd); end
    nxt;
  endtask

  task automatic test_round_robin;
    int order[$];
    int last_en = -100;
    int owner = -1;
    int cyc = 0;
    bit ok;
    do_reset;
    i_v = 1; i_a = 32'h20;
    d_v = 1; d_a = 32'h40; d_we = 0; d_w = 2;
    while (order.size() < 4 && cyc < 40) begin
      @(negedge clk);
      checks++;
      if (i_rdy && d_rdy)
        begin errors++; $display("FAIL rr_double_grant: got both ready, expected one"); end
      checks++;
      if ((i_rv && owner != 0) || (d_rv && owner != 1))
        begin errors++; $display("FAIL rr_route: got i=%b d=%b owner=%0d", i_rv, d_rv, owner); end
      if (m_en) begin
        checks++;
        if (cyc - last_en < LAT + 1)
          begin errors++; $display("FAIL rr_spacing: got %0d expected >=%0d", cyc - last_en, LAT + 1); end
        last_en = cyc;
      end
      if (i_rdy) begin order.push_back(0); owner = 0; end
      if (d_rdy) begin order.push_back(1); owner = 1; end
      nxt;
      cyc++;
    end
    ok = (order.size() == 4);
    if (ok) ok = (order[0] == 0 && order[1] == 1 && order[2] == 0 && order[3] == 1);
    checks++;
    if (!ok)
      begin errors++; $display("FAIL rr_order: got %0d grants, expected f,d,f,d", order.size()); end
    i_v = 0; d_v = 0;
    repeat (LAT + 2) nxt;
  endtask

  task automatic test_store_load;
    do_reset;
    d_v = 1; d_we = 1; d_w = 2; d_a = 32'h100; d_wd = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if ({d_rdy, m_en, m_we, m_w, m_a, m_wd} !==
        {1'b1, 1'b1, 1'b1, 3'd2, 32'h100, 32'hDEADBEEF})
      begin errors++; $display("FAIL st_issue: got %b %b %b %h %h", d_rdy, m_en, m_we, m_a, m_wd); end
    nxt;
    d_v = 0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (d_rv !== 1'b0)
        begin errors++; $display("FAIL st_early: got %b expected 0", d_rv); end
      nxt;
    end
    @(negedge clk);
    checks++;
    if ({d_rv, d_re, d_rd} !== {1'b1, 1'b0, 32'h0})
      begin errors++; $display("FAIL st_ack: got %b %b %h expected 1 0 0", d_rv, d_re, d_rd); end
    nxt;
    d_v = 1; d_we = 0; d_a = 32'h100;
    @(negedge clk);
    checks++;
    if ({d_rdy, m_en, m_we} !== 3'b110)
      begin errors++; $display("FAIL ld_issue: got %b %b %b expected 1 1 0", d_rdy, m_en, m_we); end
    nxt;
    d_v = 0;
    repeat (2) nxt;
    @(negedge clk);
    checks++;
    if ({d_rv, d_re, d_rd} !== {1'b1, 1'b0, 32'hDEADBEEF})
      begin errors++; $display("FAIL ld_data: got %b %b %h expected 1 0 deadbeef", d_rv, d_re, d_rd); end
    nxt;
  endtask

  task automatic test_misaligned;
    do_reset;
    d_v = 1; d_we = 0; d_w = 1; d_a = 32'h101;
    @(negedge clk);
    checks++;
    if ({d_rdy, m_en} !== 2'b10)
      begin errors++; $display("FAIL mis_d_issue: got %b %b expected 1 0", d_rdy, m_en); end
    nxt;
    d_v = 0;
    @(negedge clk);
    checks++;
    if ({d_rv, d_re, d_rd, i_rv} !== {1'b1, 1'b1, 32'h0, 1'b0})
      begin errors++; $display("FAIL mis_d_resp: got %b %b %h %b", d_rv, d_re, d_rd, i_rv); end
    nxt;
    i_v = 1; i_a = 32'h2;
    @(negedge clk);
    checks++;
    if ({i_rdy, m_en} !== 2'b10)
      begin errors++; $display("FAIL mis_i_issue: got %b %b expected 1 0", i_rdy, m_en); end
    nxt;
    i_v = 0;
    @(negedge clk);
    checks++;
    if ({i_rv, i_re, i_rd, d_rv} !== {1'b1, 1'b1, 32'h0, 1'b0})
      begin errors++; $display("FAIL mis_i_resp: got %b %b %h %b", i_rv, i_re, i_rd, d_rv); end
    nxt;
    d_v = 1; d_w = 4; d_a = 32'h103;
    @(negedge clk);
    checks++;
    if ({d_rdy, m_en} !== 2'b11)
      begin errors++; $display("FAIL byte_odd_issue: got %b %b expected 1 1", d_rdy, m_en); end
    nxt;
    d_v = 0;
    repeat (LAT - 1) nxt;
    @(negedge clk);
    checks++;
    if ({d_rv, d_re, d_rd} !== {1'b1, 1'b0, init_word(0)})
      begin errors++; $display("FAIL byte_odd_resp: got %b %b %h", d_rv, d_re, d_rd); end
    nxt;
  endtask

  task automatic test_flush;
    do_reset;
    i_v = 1; i_a = 32'h30;
    @(negedge clk);
    checks++;
    if ({i_rdy, m_en} !== 2'b11)
      begin errors++; $display("FAIL fl_issue: got %b %b expected 1 1", i_rdy, m_en); end
    nxt;
    i_v = 0; i_fl = 1;
    d_v = 1; d_a = 32'h40; d_we = 0; d_w = 2;
    @(negedge clk);
    checks++;
    if (d_rdy !== 1'b0)
      begin errors++; $display("FAIL fl_d_c1: got %b expected 0", d_rdy); end
    nxt;
    i_fl = 0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({i_rv, d_rdy} !== 2'b00)
        begin errors++; $display("FAIL fl_suppress: got %b %b expected 0 0", i_rv, d_rdy); end
      nxt;
    end
    @(negedge clk);
    checks++;
    if ({d_rdy, m_en, m_a} !== {1'b1, 1'b1, 32'h40})
      begin errors++; $display("FAIL fl_d_c4: got %b %b %h", d_rdy, m_en, m_a); end
    nxt;
    d_v = 0;
    repeat (LAT - 1) nxt;
    @(negedge clk);
    checks++;
    if ({d_rv, d_rd} !== {1'b1, init_word(16)})
      begin errors++; $display("FAIL fl_d_resp: got %b %h", d_rv, d_rd); end
    nxt;
  endtask

  task automatic test_reset_mid;
    do_reset;
    i_v = 1; i_a = 32'h30;
    @(negedge clk);
    nxt;
    i_v = 0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({i_rdy, d_rdy, m_en, m_a, i_rv, i_rd, i_re, d_rv, d_rd, d_re} !== '0)
      begin errors++; $display("FAIL mid_reset_outs: got nonzero, expected 0"); end
    nxt;
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if ({i_rv, d_rv} !== 2'b00)
        begin errors++; $display("FAIL mid_reset_resp: got %b %b expected 0 0", i_rv, d_rv); end
      nxt;
    end
    i_v = 1; i_a = 32'h20;
    d_v = 1; d_a = 32'h40; d_we = 0; d_w = 2;
    @(negedge clk);
    checks++;
    if ({i_rdy, d_rdy} !== 2'b10)
      begin errors++; $display("FAIL mid_reset_tie: got %b %b expected 1 0", i_rdy, d_rdy); end
    nxt;
    i_v = 0; d_v = 0;
    repeat (LAT + 2) nxt;
  endtask

  task automatic test_random;
    int free_at = 0;
    bit last_d = 1;
    bit pend = 0;
    bit p_d = 0, p_err = 0, p_we = 0, p_fl = 0;
    int p_acc = 0, p_resp = 0;
    logic [31:0] p_addr = '0;
    logic [31:0] refm [0:63];
    bit g_i, g_d, mis;
    logic e_ir, e_dr, e_en, e_we, e_irv, e_ire, e_drv, e_dre;
    logic [2:0] e_w;
    logic [31:0] e_a, e_wd, e_ird, e_drd;
    for (int k = 0; k < 64; k++) refm[k] = init_word(k);
    do_reset;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (!i_v && $urandom_range(0, 2) == 0) begin
        i_v = 1; i_a = rand_addr();
      end
      if (!d_v && $urandom_range(0, 2) == 0) begin
        d_v = 1; d_a = rand_addr();
        d_we = ($urandom_range(0, 2) == 0);
        d_w = d_we ? 3'd2 : pick_width();
        d_wd = $urandom;
      end
      i_fl = ($urandom_range(0, 5) == 0);
      @(negedge clk);
      e_ir = 0; e_dr = 0; e_en = 0; e_we = 0; e_w = 0;
      e_a = 0; e_wd = 0;
      e_irv = 0; e_ire = 0; e_ird = 0;
      e_drv = 0; e_dre = 0; e_drd = 0;
      if (pend && !p_d && cyc > p_acc && i_fl) p_fl = 1;
      if (pend && cyc == p_resp) begin
        if (p_d) begin
          e_drv = 1; e_dre = p_err;
          e_drd = (p_err || p_we) ? 32'h0 : refm[p_addr[7:2]];
        end else if (!p_fl) begin
          e_irv = 1; e_ire = p_err;
          e_ird = p_err ? 32'h0 : refm[p_addr[7:2]];
        end
        pend = 0;
      end
      g_i = 0; g_d = 0;
      if (cyc >= free_at) begin
        g_i = i_v && (!d_v || last_d);
        g_d = d_v && !g_i;
      end
      if (g_i || g_d) begin
        mis = g_i ? misaligned(0, 3'd2, i_a) : misaligned(1, d_w, d_a);
        e_ir = g_i; e_dr = g_d;
        if (!mis) begin
          e_en = 1;
          e_a = g_i ? i_a : d_a;
          e_we = g_d && d_we;
          e_w = g_i ? 3'd2 : d_w;
          e_wd = d_wd;
          if (g_d && d_we) refm[d_a[7:2]] = d_wd;
        end
        pend = 1; p_d = g_d; p_err = mis;
        p_we = g_d && d_we;
        p_addr = g_i ? i_a : d_a;
        p_fl = 0; p_acc = cyc;
        p_resp = cyc + (mis ? 1 : LAT);
        free_at = p_resp + 1;
        last_d = g_d;
      end
      checks++;
      if ({i_rdy, d_rdy, m_en} !== {e_ir, e_dr, e_en})
        begin errors++; $display("FAIL rnd_grant c%0d: got %b%b%b expected %b%b%b", cyc, i_rdy, d_rdy, m_en, e_ir, e_dr, e_en); end
      if (e_en) begin
        checks++;
        if ({m_a, m_we, m_w} !== {e_a, e_we, e_w})
          begin errors++; $display("FAIL rnd_mem c%0d: got %h %b %0d expected %h %b %0d", cyc, m_a, m_we, m_w, e_a, e_we, e_w); end
        if (e_we) begin
          checks++;
          if (m_wd !== e_wd)
            begin errors++; $display("FAIL rnd_wdata c%0d: got %h expected %h", cyc, m_wd, e_wd); end
        end
      end
      checks++;
      if ({i_rv, i_re, i_rd} !== {e_irv, e_ire, e_ird})
        begin errors++; $display("FAIL rnd_iresp c%0d: got %b %b %h expected %b %b %h", cyc, i_rv, i_re, i_rd, e_irv, e_ire, e_ird); end
      checks++;
      if ({d_rv, d_re, d_rd} !== {e_drv, e_dre, e_drd})
        begin errors++; $display("FAIL rnd_dresp c%0d: got %b %b %h expected %b %b %h", cyc, d_rv, d_re, d_rd, e_drv, e_dre, e_drd); end
      nxt;
      if (g_i) i_v = 0;
      if (g_d) d_v = 0;
    end
    i_v = 0; d_v = 0; i_fl = 0;
    repeat (LAT + 2) nxt;
  endtask

  initial begin
    reset = 1'b1;
    i_v = 0; i_a = 0; i_fl = 0;
    d_v = 0; d_a = 0; d_we = 0; d_w = 0; d_wd = 0;
    i1_v = 0; i1_a = 0;
    test_reset;
    test_fetch_lat1;
    test_round_robin;
    test_store_load;
    test_misaligned;
    test_flush;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port memory (instructions and data) between the datapath's instruction-fetch port and its load/store port.
- Uses a valid/ready request handshake and a one-cycle response pulse per requester.
- Round-robin arbitration, one outstanding transaction, fixed memory latency.
- Checks alignment before issuing; misaligned accesses are never sent to memory.

Parameters:
- MEM_LATENCY, 1, cycles from memory issue (mem_en) to valid mem_rdata; legal range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- i_req_valid  in  1  fetch request
- i_req_addr  in  32  fetch address
- i_req_ready  out  1  fetch accepted this cycle
- i_flush  in  1  cancel the in-flight fetch response
- i_resp_valid  out  1  fetch response pulse
- i_resp_data  out  32  fetched word
- i_resp_err  out  1  misaligned fetch
- d_req_valid  in  1  data request
- d_req_addr  in  32  data address
- d_req_we  in  1  1 = store
- d_req_width  in  3  0 = byte, 1 = half, 2 = word, 4 = byte unsigned, 5 = half unsigned
- d_req_wdata  in  32  store data
- d_req_ready  out  1  data request accepted
- d_resp_valid  out  1  data response pulse (loads and stores)
- d_resp_data  out  32  load data
- d_resp_err  out  1  misaligned data access
- mem_en  out  1  memory issue strobe
- mem_addr  out  32  memory address
- mem_we  out  1  memory write enable
- mem_width  out  3  memory access width
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data

Behaviour:
- Reset: asynchronous. State := IDLE; counter := 0; last_grant := DATA, so the fetch port wins the first tie.
- All outputs are 0 during reset. An in-flight transaction is dropped with no response. A store already issued may have completed in memory.
- FSM states: IDLE, WAIT, ERR.
- Ready and mem_* outputs are combinational from state plus inputs. Everything else is registered.
- Requester rule: once valid is high, the requester holds valid and payload stable until ready.
- IDLE, single requester: a valid request is granted in the same cycle (its ready = 1).
- IDLE, both requesters valid: grant the port that is not last_grant, then update last_grant.
- IDLE, granted and aligned:
  - mem_en = 1 for that one cycle.
  - mem_* carry the granted payload.
  - Fetch always drives mem_we = 0, mem_width = 2.
  - Capture the owner; counter := MEM_LATENCY - 1; go to WAIT.
- IDLE, granted and misaligned:
  - Misaligned means: half/halfu with addr[0] = 1; word with addr[1:0] != 0; any fetch with addr[1:0] != 0.
  - ready = 1, mem_en = 0; go to ERR.
- ERR (1 cycle): owner's resp_valid = 1, err = 1, data = 0; then IDLE.
- WAIT, counter != 0: decrement. Outputs hold.
- WAIT, counter == 0 (exactly MEM_LATENCY cycles after accept):
  - Owner's resp_valid = 1, err = 0, resp_data = mem_rdata (combinational pass-through); go to IDLE.
  - For stores, resp_valid is an ack and resp_data is 0.
- When no response is being signalled, resp_data is 0.
- Issue timing: no request is accepted in WAIT or ERR. The next accept is possible in the cycle after the response. Throughput is one access per MEM_LATENCY + 1 cycles.
- i_flush:
  - Sampled in every WAIT/ERR cycle while the owner is fetch, including the final cycle. If ever seen, the fetch response is suppressed.
  - The FSM still completes the wait and returns to IDLE on schedule.
  - i_flush in IDLE has no effect; an accept in the same cycle is not cancelled.
- A requester dropping valid without ready has no effect. Payload values when valid = 0 are ignored.
- last_grant updates only on accept, including misaligned accepts.

Test Plan:
- MEM_LATENCY = 1; only i_req_valid, addr 0x10; memory word 0x00500093 -> i_req_ready = 1 at cycle 0 with mem_en = 1, mem_addr = 0x10, mem_width = 2; i_resp_valid at cycle 1 with data 0x00500093; next accept no earlier than cycle 2.
- Both valid at reset exit, held -> grant order fetch, data, fetch, data; each response goes only to its owner; no two mem_en pulses closer than MEM_LATENCY + 1 cycles.
- Store word 0xDEADBEEF to 0x100, then load word 0x100, MEM_LATENCY = 3 -> store ack 3 cycles after accept with mem_we = 1 on the issue cycle; load returns 0xDEADBEEF.
- Load half at 0x101 -> mem_en stays 0, d_resp_valid = 1 with d_resp_err = 1 one cycle after accept. Fetch at 0x2 -> same on the fetch port.
- Fetch accepted, MEM_LATENCY = 3, i_flush pulsed at cycle 1 -> no i_resp_valid; a data request pending from cycle 1 is accepted at cycle 4.
- Reset asserted mid-WAIT (cycle 1 of 3) -> all outputs 0 immediately and no response afterwards; after release a simultaneous request from both ports grants fetch first.
